// File: rtl/ppg_pkg.sv
// Shared constants for the PPG sample FIFO controller: default widths,
// the ADC pacing divider default and the read FSM state encoding.
package ppg_pkg;

  localparam int PPG_WIDTH      = 10;
  localparam int PPG_SAMPLE_DIV = 100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/ppg_fifo_ctrl_if.sv
// FIFO-side strobes/flags and the downstream valid/ready sample stream.
// master = controller side, slave = FIFO plus downstream consumer side.
interface ppg_fifo_ctrl_if
  import ppg_pkg::*;
#(
  parameter int WIDTH = PPG_WIDTH
) ();

  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_full;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  // out_valid rises only once a word is loaded; it stays high with out_data
  // frozen until a cycle with out_ready=1, which completes the transfer.
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data,
    input  fifo_full, fifo_dout, fifo_empty, out_ready
  );

  modport slave (
    input  fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data,
    output fifo_full, fifo_dout, fifo_empty, out_ready
  );

endinterface

// File: rtl/ppg_tick_gen.sv
// ADC pacing divider: a registered one-cycle adc_start every SAMPLE_DIV
// cycles while enable is high; the count is held at 0 while disabled.
module ppg_tick_gen
  import ppg_pkg::*;
#(
  parameter int SAMPLE_DIV = PPG_SAMPLE_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic adc_start
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  // Registering the pulse makes the first start land SAMPLE_DIV cycles
  // after enable rises and keeps adc_start free of any input path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      adc_start <= 1'b0;
    end else if (!enable) begin
      cnt       <= '0;
      adc_start <= 1'b0;
    end else begin
      adc_start <= (cnt == LAST);
      cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ppg_fifo_ctrl.sv
// PPG sample FIFO controller: paces the ADC, writes samples (dropping when
// full) and drains the FIFO into a valid/ready stream.
// Optional: PPG_CTRL_DROP_CNT_EN builds the saturating drop counter.
module ppg_fifo_ctrl
  import ppg_pkg::*;
#(
  parameter int WIDTH      = PPG_WIDTH,
  parameter int SAMPLE_DIV = PPG_SAMPLE_DIV,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             adc_start,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  ppg_fifo_ctrl_if.master  bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       rd_state
);

  logic [1:0]       state;
  logic             wr_en_q;
  logic [WIDTH-1:0] din_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  ppg_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .adc_start(adc_start)
  );

  // Write path runs regardless of enable; din holds when no write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      din_q   <= '0;
    end else begin
      wr_en_q <= adc_valid && !bus.fifo_full;
      if (adc_valid && !bus.fifo_full) din_q <= adc_data;
    end
  end

`ifdef PPG_CTRL_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (adc_valid && bus.fifo_full && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  // Read FSM: one word per pass; no read is issued while a word is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (!bus.fifo_empty) state <= ST_FETCH;
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          out_data_q  <= bus.fifo_dout;
          out_valid_q <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_din   = din_q;
  assign bus.fifo_rd_en = (state == ST_FETCH);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign rd_state       = state;

endmodule

// File: tb/tb_ppg_fifo_ctrl.sv
// Directed bench for ppg_fifo_ctrl with a 4-deep behavioural FIFO and a
// scoreboard on the output stream.
module tb_ppg_fifo_ctrl;

  localparam int W     = 10;
  localparam int CNT_W = 2;
  localparam int DEPTH = 4;
`ifdef PPG_CTRL_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             adc_start;
  logic             adc_valid = 1'b0;
  logic [W-1:0]     adc_data = '0;
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0]       rd_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] last_din = '0;

  ppg_fifo_ctrl_if #(.WIDTH(W)) bus ();

  ppg_fifo_ctrl #(.WIDTH(W), .SAMPLE_DIV(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .adc_start(adc_start),
    .adc_valid(adc_valid),
    .adc_data (adc_data),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .rd_state (rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // behavioural FIFO: registered flags, dout valid one cycle after rd_en
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q.delete();
      bus.fifo_full  <= 1'b0;
      bus.fifo_empty <= 1'b1;
      bus.fifo_dout  <= '0;
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
      if (bus.fifo_wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(bus.fifo_din);
      bus.fifo_full  <= (fifo_q.size() >= DEPTH);
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // scoreboard on accepted output words
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", exp_q.size(), 1);
      else check("sb_data", bus.out_data, exp_q.pop_front());
    end
  end

  // driver: one adc_valid pulse, then the registered write one cycle later
  task automatic send(input logic [W-1:0] d, input bit acc);
    @(posedge clk); #1;
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(negedge clk);
    check("wr_en", bus.fifo_wr_en, acc);
    if (acc) begin
      last_din = d;
      exp_q.push_back(d);
    end
    check("fifo_din", bus.fifo_din, last_din);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_wr_en"}, bus.fifo_wr_en, 0);
    check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_fifo_din"}, bus.fifo_din, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_state"}, rd_state, 0);
  endtask

  initial begin
    logic [W-1:0] vals[3];
    bit seen;
    int exp_drop;
    vals[0] = 10'd5; vals[1] = 10'd17; vals[2] = 10'd1023;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1 reset = 1'b0;

    // tick divider: pulses at 4 and 8, none at 12 after disable, 18 after re-enable
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      if (k == 0)  enable = 1'b1;
      if (k == 10) enable = 1'b0;
      if (k == 14) enable = 1'b1;
      @(negedge clk);
      check($sformatf("tick_c%0d", k), adc_start, (k == 4 || k == 8 || k == 18));
    end
    @(posedge clk); #1 enable = 1'b0;

    // write/drain with immediate ready: out_valid 3 cycles after empty falls
    for (int i = 0; i < 3; i++) begin
      send(vals[i], 1'b1);
      seen = 1'b0;
      for (int j = 0; j < 10 && !seen; j++) begin
        @(negedge clk);
        seen = !bus.fifo_empty;
      end
      check("empty_fall", seen, 1);
      @(negedge clk); check("lat_m1", bus.out_valid, 0);
      check("lat_rd_en", bus.fifo_rd_en, 1);
      @(negedge clk); check("lat_m2", bus.out_valid, 0);
      @(negedge clk); check("lat_m3", bus.out_valid, 1);
      check("lat_data", bus.out_data, vals[i]);
      @(negedge clk); check("one_cycle", bus.out_valid, 0);
      repeat (3) @(posedge clk);
    end
    check("drain3_done", exp_q.size(), 0);

    // overflow: one word held, four fill the FIFO, the sixth is dropped
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(10'(100 + i), (i < 5));
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    check("drop_overflow", drop_cnt, DROP_ON);

    // backpressure in HOLD
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_data", bus.out_data, 100);
      check("bp_rd_en", bus.fifo_rd_en, 0);
    end

    // saturation: further drops pin a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      send(10'(200 + i), 1'b0);
      @(negedge clk);
      exp_drop = (2 + i > 3) ? 3 : 2 + i;
      check("drop_sat", drop_cnt, DROP_ON * exp_drop);
    end

    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("drain5_done", exp_q.size(), 0);
    check("drain5_idle", bus.out_valid, 0);

    // reset during FETCH
    send(10'd300, 1'b1);
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = bus.fifo_rd_en;
    end
    check("reach_fetch", seen, 1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_fetch");
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    last_din = '0;

    // reset during HOLD
    bus.out_ready = 1'b0;
    send(10'd301, 1'b1);
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("reach_hold", seen, 1);
    check("hold_state", rd_state, 3);
    reset = 1'b1;
    #1;
    check_all_zero("rst_hold");
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    last_din = '0;

    // restart from IDLE after reset
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("restart_idle", rd_state, 0);
    send(10'd302, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("restart_done", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppg_fifo_ctrl.md
# ppg_fifo_ctrl

Sequencing controller for the PPG sample FIFO (`ppg_interface`) in the BPM system. It paces the PPG ADC with a programmable sample tick and writes each returned sample into the FIFO. Samples that arrive while the FIFO is full are dropped and counted. On the read side it drains the FIFO one word at a time into a valid/ready stream consumed by the BPM computation stage.

## Interface
Parameters:
- `WIDTH`, 10, sample width; must match the FIFO.
- `SAMPLE_DIV`, 100, clk cycles per ADC start pulse; legal range is 4 or more.
- `CNT_W`, 8, drop counter width.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `enable` input 1: runs the sample tick; when 0 the divider is held at 0.
- `adc_start` output 1: one-cycle conversion request to the ADC.
- `adc_valid` input 1: one-cycle pulse; `adc_data` is valid in that cycle.
- `adc_data` input WIDTH: ADC sample.
- `fifo_wr_en` output 1: FIFO write strobe.
- `fifo_din` output WIDTH: FIFO write data.
- `fifo_full` input 1: FIFO full flag.
- `fifo_rd_en` output 1: FIFO read strobe.
- `fifo_dout` input WIDTH: FIFO read data; valid one cycle after `fifo_rd_en`.
- `fifo_empty` input 1: FIFO empty flag.
- `out_valid` output 1: output sample available.
- `out_data` output WIDTH: output sample.
- `out_ready` input 1: downstream accepts the sample.
- `drop_cnt` output CNT_W: saturating count of dropped samples.

## Operation
- **Tick divider.**
  - Counts 0..SAMPLE_DIV-1 while `enable`=1.
  - `adc_start`=1 in the cycle the count equals SAMPLE_DIV-1; the count then wraps to 0.
  - `enable`=0 clears the count and suppresses `adc_start`.
- **Write path.**
  - In a cycle with `adc_valid`=1: if `fifo_full`=0, register `fifo_wr_en`=1 and `fifo_din`=`adc_data` for the next cycle.
  - If `fifo_full`=1, no write is issued and `drop_cnt` increments. It saturates at all-ones.
  - `fifo_din` holds its last value when `fifo_wr_en`=0.
- **Read FSM.** States: IDLE, FETCH, LOAD, HOLD.
  - IDLE -> FETCH when `fifo_empty`=0.
  - FETCH: `fifo_rd_en`=1 (Moore decode); next state is LOAD.
  - LOAD: `out_data` <= `fifo_dout`, `out_valid` <= 1; next state is HOLD.
  - HOLD: `out_valid`=1 and `out_data` stable until `out_ready`=1. Then `out_valid` <= 0 and next state is IDLE.
  - A read is never issued while a sample is held.
- **Simultaneous events.**
  - Write and read of the FIFO in the same cycle are legal. The two paths are independent.
  - `adc_valid` with `enable`=0 is still serviced; the write path ignores `enable`.
- **Reset (including mid-transfer).** Asserting `reset` forces:
  - FSM to IDLE
  - `adc_start`, `fifo_wr_en`, `fifo_rd_en`, `out_valid` to 0
  - `out_data`, `fifo_din`, `drop_cnt`, divider to 0

  A held sample is discarded. FIFO contents are the FIFO's own responsibility.

## Timing
- All outputs are registered or decoded from registered state. No combinational input-to-output path.
- Write latency: `adc_valid` at cycle n gives `fifo_wr_en` at cycle n+1.
- Read latency: `fifo_empty`=0 sampled in IDLE at cycle n gives:
  - `fifo_rd_en` at n+1
  - `out_valid` rising at n+3
- Throughput: one sample per 4 cycles at best (IDLE, FETCH, LOAD, HOLD with immediate `out_ready`). This exceeds the sample rate because SAMPLE_DIV is at least 4.
- First `adc_start` comes SAMPLE_DIV cycles after `enable` rises.

## Configuration
- `PPG_CTRL_DROP_CNT_EN`
  - Defined: the saturating drop counter is built and drives `drop_cnt`.
  - Undefined: no counter register is built and `drop_cnt` is tied to 0. Drop behaviour (no write when full) is unchanged.

## Structure
- Shared package `ppg_pkg` holds:
  - read FSM state encoding (IDLE=0, FETCH=1, LOAD=2, HOLD=3)
  - the default `WIDTH`
  - `SAMPLE_DIV` default constant
- One natural sub-module: `ppg_tick_gen`, the divider producing `adc_start`, parameterised by SAMPLE_DIV.
- FSM and write path stay in the top module.

## Test plan
- **Tick:** SAMPLE_DIV=4, `enable`=1 from cycle 0 -> `adc_start` at cycles 4, 8, 12. Drop `enable` at cycle 10 -> no pulse at 12; divider is 0.
- **Write/drain:** three `adc_valid` pulses with data 5, 17, 1023, `out_ready`=1 -> `out_data` sequence 5, 17, 1023. Each `out_valid` is one cycle, first at 3 cycles after `fifo_empty` falls.
- **Overflow:** `out_ready`=0, six samples into DEPTH=4 FIFO -> 4 writes plus 1 held in HOLD, so 5 accepted and 1 dropped, `drop_cnt`=1. With the macro undefined -> `drop_cnt`=0.
- **Backpressure:** `out_ready`=0 for 20 cycles in HOLD -> `out_valid` stays 1, `out_data` stable, `fifo_rd_en` stays 0.
- **Saturation:** CNT_W=2, 5 drops -> `drop_cnt`=3.
- **Reset mid-transfer:** assert `reset` during FETCH and again during HOLD -> all outputs 0 asynchronously; after release the FSM restarts from IDLE.
